// File: rtl/alu_issue_arbiter_pkg.sv
// Shared ALU opcode encodings and constants for the issue arbiter and its ALU.
package alu_issue_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_NOP = 4'd15
    } alu_op_t;

    localparam int ALU_W = 32;

    // Marker value the ALU produces for a NOP, so a NOP is visible at writeback.
    localparam logic [ALU_W-1:0] ALU_NOP_RESULT = 32'h000E_2202;

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Request/response bundle between issue slots, the arbiter and writeback.
interface alu_issue_arbiter_if
    import alu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_operand_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_operand_b;
    alu_op_t [NUM_REQ-1:0]          req_alu_op;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [DATA_W-1:0]              resp_result;
    logic [ID_W-1:0]                resp_id;

    modport master (
        output req_valid, req_operand_a, req_operand_b, req_alu_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_id
    );

    modport slave (
        input  req_valid, req_operand_a, req_operand_b, req_alu_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_id
    );

endinterface

// File: rtl/alu_issue_arbiter_alu.sv
// Combinational 32-bit ALU shared by all issue slots.
module alu_issue_arbiter_alu
    import alu_issue_arbiter_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  alu_op_t          op,
    output logic [ALU_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            ALU_SRA: y = $signed(a) >>> b[4:0];
            ALU_NOP: y = ALU_NOP_RESULT;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ issue slots, with a
// single registered, id-tagged result behind a valid/ready handshake.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_arbiter_if.slave bus,
    output logic [15:0]        busy_count
);

    logic [ID_W-1:0]   rr_ptr;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_result_q;
    logic [ID_W-1:0]   resp_id_q;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              can_accept;
    logic              fire;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    alu_op_t           alu_op;

    // Scan from the highest offset down so the closest slot to rr_ptr wins;
    // the index wraps for free because NUM_REQ is a power of two.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] idx;
        rr_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + ID_W'(i);
            if (valid[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    always_comb begin
        {grant_found, grant_idx} = rr_pick(bus.req_valid, rr_ptr);
    end

    assign can_accept = !resp_valid_q || bus.resp_ready;
    assign fire       = grant_found && can_accept && !rst;

    always_comb begin
        bus.req_ready = '0;
        if (fire) bus.req_ready[grant_idx] = 1'b1;
    end

    assign alu_a  = bus.req_operand_a[grant_idx];
    assign alu_b  = bus.req_operand_b[grant_idx];
    assign alu_op = bus.req_alu_op[grant_idx];

    alu_issue_arbiter_alu u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_id_q     <= '0;
            rr_ptr        <= '0;
            busy_count    <= '0;
        end else begin
            if (fire) begin
                resp_valid_q  <= 1'b1;
                resp_result_q <= alu_y;
                resp_id_q     <= grant_idx;
                rr_ptr        <= grant_idx + ID_W'(1);
            end else if (bus.resp_ready) begin
                resp_valid_q  <= 1'b0;
            end
            if (resp_valid_q && !bus.resp_ready && busy_count != 16'hFFFF)
                busy_count <= busy_count + 16'd1;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_id     = resp_id_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: vector table plus hand-written
// backpressure and reset sequences.
module tb_alu_issue_arbiter;
    import alu_issue_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] busy_count;

    alu_issue_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

    alu_issue_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       vld;
        logic             rdy;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][3:0]  op;
        logic [3:0]       exp_ready;
        logic             exp_valid;
        logic [31:0]      exp_result;
        logic [1:0]       exp_id;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [3:0] OA = ALU_ADD;
    localparam logic [3:0] OS = ALU_SUB;
    localparam logic [3:0] ON = ALU_NOP;
    localparam logic [3:0] OR = ALU_SRA;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] vld, input logic rdy,
                         input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                         input logic [3:0][3:0] op);
        bus.req_valid     = vld;
        bus.resp_ready    = rdy;
        bus.req_operand_a = a;
        bus.req_operand_b = b;
        for (int i = 0; i < 4; i++) bus.req_alu_op[i] = alu_op_t'(op[i]);
    endtask

    function automatic vec_t mk(input logic [3:0] vld, input logic rdy,
                                input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                                input logic [3:0][3:0] op, input logic [3:0] er,
                                input logic ev, input logic [31:0] eres, input logic [1:0] eid);
        vec_t v;
        v.vld = vld; v.rdy = rdy; v.a = a; v.b = b; v.op = op;
        v.exp_ready = er; v.exp_valid = ev; v.exp_result = eres; v.exp_id = eid;
        return v;
    endfunction

    initial begin
        logic [3:0][31:0] a_idx;
        logic [3:0][31:0] b_100;
        logic [3:0][3:0]  all_add;
        a_idx   = {32'd3, 32'd2, 32'd1, 32'd0};
        b_100   = {32'd100, 32'd100, 32'd100, 32'd100};
        all_add = {OA, OA, OA, OA};

        // single requester SUB, then slot 3 to bring rr_ptr back to 0
        vecs.push_back(mk(4'b0010, 1'b1, {32'd0, 32'd0, 32'd7, 32'd0}, {32'd0, 32'd0, 32'd5, 32'd0},
                          {OA, OA, OS, OA}, 4'b0010, 1'b1, 32'd2, 2'd1));
        vecs.push_back(mk(4'b1000, 1'b1, a_idx, b_100, all_add, 4'b1000, 1'b1, 32'd103, 2'd3));
        // fairness with all slots valid
        vecs.push_back(mk(4'b1111, 1'b1, a_idx, b_100, all_add, 4'b0001, 1'b1, 32'd100, 2'd0));
        vecs.push_back(mk(4'b1111, 1'b1, a_idx, b_100, all_add, 4'b0010, 1'b1, 32'd101, 2'd1));
        vecs.push_back(mk(4'b1111, 1'b1, a_idx, b_100, all_add, 4'b0100, 1'b1, 32'd102, 2'd2));
        vecs.push_back(mk(4'b1111, 1'b1, a_idx, b_100, all_add, 4'b1000, 1'b1, 32'd103, 2'd3));
        vecs.push_back(mk(4'b1111, 1'b1, a_idx, b_100, all_add, 4'b0001, 1'b1, 32'd100, 2'd0));
        // NOP and SRA through slot 2
        vecs.push_back(mk(4'b0100, 1'b1, {32'd0, 32'h8000_0000, 32'd0, 32'd0}, {32'd0, 32'd4, 32'd0, 32'd0},
                          {OA, ON, OA, OA}, 4'b0100, 1'b1, 32'h000E_2202, 2'd2));
        vecs.push_back(mk(4'b0100, 1'b1, {32'd0, 32'h8000_0000, 32'd0, 32'd0}, {32'd0, 32'd4, 32'd0, 32'd0},
                          {OA, OR, OA, OA}, 4'b0100, 1'b1, 32'hF800_0000, 2'd2));
        // rr_ptr is 3 here: wrap to 0, skip 1, then 2, then 0 again
        vecs.push_back(mk(4'b0101, 1'b1, {32'd0, 32'd2, 32'd0, 32'd1}, {32'd0, 32'd2, 32'd0, 32'd1},
                          all_add, 4'b0001, 1'b1, 32'd2, 2'd0));
        vecs.push_back(mk(4'b0101, 1'b1, {32'd0, 32'd2, 32'd0, 32'd1}, {32'd0, 32'd2, 32'd0, 32'd1},
                          all_add, 4'b0100, 1'b1, 32'd4, 2'd2));
        vecs.push_back(mk(4'b0101, 1'b1, {32'd0, 32'd2, 32'd0, 32'd1}, {32'd0, 32'd2, 32'd0, 32'd1},
                          all_add, 4'b0001, 1'b1, 32'd2, 2'd0));
        // idle drain: valid drops, result and id hold
        vecs.push_back(mk(4'b0000, 1'b1, a_idx, b_100, all_add, 4'b0000, 1'b0, 32'd2, 2'd0));

        // reset, with requests pending to show req_ready is gated
        rst = 1'b1;
        drive(4'b1111, 1'b1, a_idx, b_100, all_add);
        step();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_result", bus.resp_result, 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_busy_count", 32'(busy_count), 32'd0);
        rst = 1'b0;
        drive(4'b0000, 1'b1, a_idx, b_100, all_add);
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].rdy, vecs[i].a, vecs[i].b, vecs[i].op);
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            step();
            chk($sformatf("v%0d_resp_valid", i), 32'(bus.resp_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_resp_result", i), bus.resp_result, vecs[i].exp_result);
            chk($sformatf("v%0d_resp_id", i), 32'(bus.resp_id), 32'(vecs[i].exp_id));
        end

        // backpressure: rr_ptr is 1, so slot 1 fires the overflowing add
        drive(4'b0010, 1'b1, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0}, {32'd0, 32'd0, 32'd1, 32'd0}, all_add);
        step();
        chk("bp_first_result", bus.resp_result, 32'd0);
        chk("bp_first_id", 32'(bus.resp_id), 32'd1);
        drive(4'b1111, 1'b0, a_idx, b_100, all_add);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
            step();
            chk($sformatf("bp%0d_resp_valid", c), 32'(bus.resp_valid), 32'd1);
            chk($sformatf("bp%0d_resp_result", c), bus.resp_result, 32'd0);
        end
        chk("bp_busy_count", 32'(busy_count), 32'd5);
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 32'(bus.req_ready), 32'b0100);
        step();
        chk("bp_release_result", bus.resp_result, 32'd102);
        chk("bp_release_id", 32'(bus.resp_id), 32'd2);
        chk("bp_release_busy", 32'(busy_count), 32'd5);

        // reset while a result is stalled
        bus.resp_ready = 1'b0;
        step();
        chk("mid_busy_count", 32'(busy_count), 32'd6);
        rst = 1'b1;
        step();
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_busy_count", 32'(busy_count), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        drive(4'b1001, 1'b1, {32'd40, 32'd0, 32'd0, 32'd10}, {32'd50, 32'd0, 32'd0, 32'd20}, all_add);
        #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'b0001);
        step();
        chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("post_rst_result", bus.resp_result, 32'd30);
        chk("post_rst_id", 32'(bus.resp_id), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one combinational alu instance between NUM_REQ requesters (warp/lane issue slots) using round-robin arbitration.
- The granted request's operands and alu_op go through the ALU. The result is captured in a single output register with a valid/ready handshake, tagged with the requester index.
- Sits between per-slot issue logic and writeback. It is the only path into the ALU.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, 2..16)
- DATA_W, 32, operand/result width; the ALU is fixed at 32, so only 32 is legal
- ID_W, $clog2(NUM_REQ), width of resp_id

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_operand_a  in  NUM_REQ x DATA_W  operand A per requester
- req_operand_b  in  NUM_REQ x DATA_W  operand B per requester
- req_alu_op  in  NUM_REQ x alu_op_t  operation per requester
- resp_valid  out  1  result register holds a valid result
- resp_ready  in  1  downstream accepts result
- resp_result  out  DATA_W  ALU result
- resp_id  out  ID_W  index of the requester that produced resp_result
- busy_count  out  16  saturating count of cycles with resp_valid=1 and resp_ready=0 (stall statistic)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: resp_valid=0, resp_result=0, resp_id=0, busy_count=0, rr_ptr=0.
  - During reset, req_ready is all zeros.
  - Reset mid-operation drops any held result with no response.
- can_accept = !resp_valid || resp_ready. Same-cycle drain-and-refill is allowed, giving full throughput of one op per cycle.
- Arbitration (combinational):
  - Priority order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - grant = first requester in that order with req_valid=1.
  - req_ready[grant] = can_accept; all other bits are 0.
  - With no valid request, req_ready=0.
- Handshake fire = req_valid[g] && req_ready[g]. On fire, at the next clk edge:
  - resp_result <= alu(result) for requester g's operands/op;
  - resp_id <= g; resp_valid <= 1;
  - rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Latency: exactly 1 cycle from fire to resp_valid.
- If resp_valid && resp_ready && no fire: resp_valid <= 0 and resp_result/resp_id hold their last values.
- If resp_valid && !resp_ready: all result state holds, no grant is issued, and rr_ptr holds.
- rr_ptr advances only on fire. Idle cycles do not rotate priority.
- Fairness: with all requesters continuously valid and resp_ready=1, grants go 0,1,2,3,0,...
- Request stability: requesters must hold operands/op stable while valid and not ready. The block does not check this.
- ALU_NOP passes through the ALU unchanged, so the result is the ALU's NOP constant 32'hE2202. No special-casing.
- busy_count: increments when resp_valid && !resp_ready and saturates at 16'hFFFF.

Decomposition:
- Shared package common: alu_op_t and ALU_* encodings (already present).
- Add ALU_NOP_RESULT = 32'hE2202 so benches do not hardcode it.
- Sub-module: the existing alu, instantiated once, fed by a mux on grant.
- Round-robin grant logic may be a local function. It is not a separate module.

Test Plan:
1. Single requester: req_valid=4'b0010 with A=7, B=5, ALU_SUB, resp_ready=1 -> req_ready=4'b0010 that cycle; next cycle resp_valid=1, resp_result=2, resp_id=1; rr_ptr then 2.
2. All four valid continuously with ALU_ADD, A=i, B=100, resp_ready=1 -> one response per cycle, resp_id sequence 0,1,2,3,0, results 100,101,102,103,100.
3. Backpressure: one fire of A=32'hFFFF_FFFF, B=1, ALU_ADD, then resp_ready=0 for 5 cycles with req_valid=4'b1111 -> resp_result=0 and resp_valid stay held, req_ready=0 throughout, busy_count=5; on resp_ready=1, a new grant fires the same cycle.
4. Wrap and skip: rr_ptr=3, req_valid=4'b0101 -> grant 0, then grant 2, then grant 0.
5. ALU_NOP and ALU_SRA via requester 2, A=32'h8000_0000, B=4 -> results 32'hE2202 and 32'hF800_0000, resp_id=2.
6. Reset mid-operation: assert rst while resp_valid=1 and resp_ready=0 -> next cycle resp_valid=0, busy_count=0, req_ready=0; after deassert, requester 0 wins a tie against 3.
